// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: encodings, FSM state type and the round-robin pick helper
// shared by the rr_mux_arbiter block.
//   SEL_REQ0..SEL_REQ2 : mux select codes for requesters 0..2
//   SEL_IDLE           : select code that routes the all-zero input
//   state_t            : arbiter FSM states {IDLE, GRANT}
//   rr_pick()          : round-robin winner index from req and last winner
package rr_arb_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Search starts at last+1 and wraps 2->0, so the previous winner is
    // checked last. Walking the offsets from far to near lets the nearest
    // requester overwrite any farther one. Returns last when req is zero;
    // callers only use the result when some request is present.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         last);
        logic [1:0] win;
        int         idx;
        win = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) win = 2'(idx);
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// mux_4to1: combinational 4-to-1 multiplexer.
//   a, b, c, d : WIDTH-bit inputs selected by sel = 00, 01, 10, 11
//   sel        : 2-bit select
//   y          : selected input
module mux_4to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one WIDTH-bit port between
// three requesters by steering the select of a 4-to-1 mux. A grant is held
// until the shared resource pulses done; a pending request at that point is
// handed the port on the very next cycle.
//
// Optional feature (macro RR_MUX_ARBITER_TIMEOUT_EN): a grant held TIMEOUT
// cycles without done is released as if done had arrived, and timeout pulses
// for one cycle. Without the macro no hold counter exists and timeout is 0.
//
// Ports:
//   clk      : clock, all state on rising edge
//   rst_n    : synchronous active-low reset
//   req      : per-requester request, bit i = requester i
//   done     : end of current transaction, only looked at while busy
//   a, b, c  : payloads of requesters 0, 1, 2
//   gnt      : registered one-hot grant, zero when idle
//   sel      : registered mux select, 11 = idle
//   busy     : registered, high while a grant is held
//   data_out : combinational mux output, zero when sel = 11
//   timeout  : one-cycle pulse on forced release
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic               busy,
    output logic [WIDTH-1:0]   data_out,
    output logic               timeout
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_mux_arbiter: TIMEOUT must be in 2..255");
    end

    state_t             state;
    state_t             state_next;
    logic [1:0]         last;
    logic [1:0]         last_next;
    logic [1:0]         sel_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic               busy_next;
    logic [1:0]         winner;
    logic               expire;
    logic               release_ev;
    logic               grab;

    assign winner     = rr_pick(req, last);
    assign release_ev = (state == GRANT) && (done || expire);
    // A new grant is issued from IDLE or on the release edge of a grant.
    assign grab       = ((state == IDLE) || release_ev) && (|req);

`ifdef RR_MUX_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // done on the expiry cycle wins, so no timeout pulse in that case.
    assign expire = (state == GRANT) && !done &&
                    (hold_cnt == HOLD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= expire;
            if (grab)
                hold_cnt <= '0;
            else if (state == GRANT && !release_ev)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= SEL_REQ2;
            sel   <= SEL_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            last  <= last_next;
            sel   <= sel_next;
            gnt   <= gnt_next;
            busy  <= busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|req) state_next = GRANT;
            end
            GRANT: begin
                if (release_ev && !(|req)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs. The winner index doubles as
    // its select code because SEL_REQn == n.
    always_comb begin
        last_next = last;
        sel_next  = sel;
        gnt_next  = gnt;
        busy_next = busy;
        if (grab) begin
            last_next = winner;
            sel_next  = winner;
            gnt_next  = 3'b001 << winner;
            busy_next = 1'b1;
        end else if (release_ev) begin
            sel_next  = SEL_IDLE;
            gnt_next  = '0;
            busy_next = 1'b0;
        end
    end

    mux_4to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   ('0),
        .sel (sel),
        .y   (data_out)
    );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: vector table plus hand-written sequences for the
// rr_mux_arbiter block. Each step drives inputs, queues the outputs expected
// after the next rising edge, and compares them one cycle later.
module tb_rr_mux_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req;
    logic             done;
    logic [WIDTH-1:0] a, b, c;
    logic [2:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             timeout;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic       done;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rr_mux_arbiter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .a        (a),
        .b        (b),
        .c        (c),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .data_out (data_out),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] exp_data(input logic [1:0] s);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return '0;
        endcase
    endfunction

    task automatic step(input string name, input logic r, input logic [2:0] rq,
                        input logic d, input logic [2:0] eg, input logic [1:0] es,
                        input logic eb, input logic eto);
        exp_t e;
        logic [WIDTH-1:0] ed;
        rst_n = r;
        req   = rq;
        done  = d;
        a     = $urandom;
        b     = $urandom;
        c     = $urandom;
        e.gnt = eg; e.sel = es; e.busy = eb; e.to = eto;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        ed = exp_data(e.sel);
        n_vec++;
        if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy ||
            timeout !== e.to || data_out !== ed) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%b busy=%b to=%b data=%h, want gnt=%b sel=%b busy=%b to=%b data=%h",
                     name, gnt, sel, busy, timeout, data_out,
                     e.gnt, e.sel, e.busy, e.to, ed);
        end
    endtask

    function automatic void add(input logic r, input logic [2:0] rq, input logic d,
                                input logic [2:0] eg, input logic [1:0] es,
                                input logic eb);
        vec_t v;
        v.rst_n = r; v.req = rq; v.done = d; v.gnt = eg; v.sel = es; v.busy = eb;
        tbl.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0; req = '0; done = 1'b0; a = '0; b = '0; c = '0;

        // reset with all requesting, then first grant to requester 0
        add(0, 3'b111, 0, 3'b000, 2'b11, 0);
        add(0, 3'b111, 0, 3'b000, 2'b11, 0);
        add(1, 3'b111, 0, 3'b001, 2'b00, 1);
        // steady 111 with done every third cycle: 0,1,2,0,1,2
        add(1, 3'b111, 0, 3'b001, 2'b00, 1);
        add(1, 3'b111, 1, 3'b010, 2'b01, 1);
        add(1, 3'b111, 0, 3'b010, 2'b01, 1);
        add(1, 3'b111, 0, 3'b010, 2'b01, 1);
        add(1, 3'b111, 1, 3'b100, 2'b10, 1);
        add(1, 3'b111, 0, 3'b100, 2'b10, 1);
        add(1, 3'b111, 0, 3'b100, 2'b10, 1);
        add(1, 3'b111, 1, 3'b001, 2'b00, 1);
        add(1, 3'b111, 0, 3'b001, 2'b00, 1);
        add(1, 3'b111, 0, 3'b001, 2'b00, 1);
        add(1, 3'b111, 1, 3'b010, 2'b01, 1);
        add(1, 3'b111, 0, 3'b010, 2'b01, 1);
        add(1, 3'b111, 0, 3'b010, 2'b01, 1);
        add(1, 3'b111, 1, 3'b100, 2'b10, 1);
        // only requester 2: wrap and self-regrant, then release to idle
        add(1, 3'b100, 0, 3'b100, 2'b10, 1);
        add(1, 3'b100, 1, 3'b100, 2'b10, 1);
        add(1, 3'b000, 1, 3'b000, 2'b11, 0);
        // done while idle is ignored
        add(1, 3'b000, 1, 3'b000, 2'b11, 0);
        add(1, 3'b000, 0, 3'b000, 2'b11, 0);
        // requester 1 drops req mid-transaction: grant held until done
        add(1, 3'b010, 0, 3'b010, 2'b01, 1);
        add(1, 3'b000, 0, 3'b010, 2'b01, 1);
        add(1, 3'b000, 0, 3'b010, 2'b01, 1);
        add(1, 3'b000, 1, 3'b000, 2'b11, 0);
        // last=1: 101 picks 2, then 0, then 0 again as sole requester
        add(1, 3'b101, 0, 3'b100, 2'b10, 1);
        add(1, 3'b101, 1, 3'b001, 2'b00, 1);
        add(1, 3'b001, 1, 3'b001, 2'b00, 1);
        add(1, 3'b110, 0, 3'b001, 2'b00, 1);
        // reset mid-grant, then last is back to 2 so requester 1 wins
        add(0, 3'b111, 0, 3'b000, 2'b11, 0);
        add(1, 3'b010, 0, 3'b010, 2'b01, 1);
        add(1, 3'b000, 1, 3'b000, 2'b11, 0);

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].done,
                 tbl[i].gnt, tbl[i].sel, tbl[i].busy, 1'b0);

`ifdef RR_MUX_ARBITER_TIMEOUT_EN
        // last=1 here; requester 0 held TIMEOUT cycles without done
        step("to_grant", 1, 3'b001, 0, 3'b001, 2'b00, 1, 0);
        for (int i = 0; i < TIMEOUT - 1; i++)
            step($sformatf("to_hold%0d", i), 1, 3'b000, 0, 3'b001, 2'b00, 1, 0);
        step("to_expire", 1, 3'b000, 0, 3'b000, 2'b11, 0, 1);
        step("to_pulse_end", 1, 3'b000, 0, 3'b000, 2'b11, 0, 0);
        // done arriving on the expiry cycle: normal release, no pulse
        step("dn_grant", 1, 3'b001, 0, 3'b001, 2'b00, 1, 0);
        for (int i = 0; i < TIMEOUT - 1; i++)
            step($sformatf("dn_hold%0d", i), 1, 3'b000, 0, 3'b001, 2'b00, 1, 0);
        step("dn_release", 1, 3'b000, 1, 3'b000, 2'b11, 0, 0);
        step("dn_idle", 1, 3'b000, 0, 3'b000, 2'b11, 0, 0);
`else
        // without the timeout feature a grant is held indefinitely
        step("hold_grant", 1, 3'b001, 0, 3'b001, 2'b00, 1, 0);
        for (int i = 0; i < 110; i++)
            step($sformatf("hold%0d", i), 1, 3'b000, 0, 3'b001, 2'b00, 1, 0);
        step("hold_release", 1, 3'b000, 1, 3'b000, 2'b11, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
